// File: rtl/mod_instruction_fetch_ctrl.sv
// Instruction fetch sequencer: drives the ROM word address from the PC and keeps a one-entry IF/ID slot.
// Optional macro FETCH_COUNT_EN adds a 32-bit count of IF/ID transfers on port fetch_count.
module mod_instruction_fetch_ctrl #(
    parameter int unsigned        ADDR_W   = 30,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_instruction,
    input  logic              rom_mem_end,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              busy,
    output logic              halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [DATA_W-1:0] if_instr_r;
    logic [DATA_W-1:0] if_instr_next_s;
    logic [ADDR_W-1:0] if_pc_r;
    logic [ADDR_W-1:0] if_pc_next_s;
    logic              if_valid_r;
    logic              if_valid_next_s;
    logic              busy_r;
    logic              halted_r;

    logic              slot_free_s;
    logic              start_ok_s;
    logic              fire_s;
    logic              xfer_s;

    // Handshake qualifiers shared by the datapath and the counter.
    always_comb begin
        slot_free_s = !if_valid_r || id_ready;
        start_ok_s  = start && (state_r != ST_FETCH) && !redirect_valid;
        fire_s      = (state_r == ST_FETCH) && slot_free_s && !rom_mem_end && !redirect_valid;
        xfer_s      = if_valid_r && id_ready && !redirect_valid;
    end

    // Next-state decode; a redirect overrides everything, including start.
    always_comb begin
        state_next_s = state_r;
        if (redirect_valid) begin
            state_next_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (rom_mem_end && slot_free_s) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_HALT;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // PC and IF/ID slot update; a pending word with no accepting decode simply holds.
    always_comb begin
        pc_next_s       = pc_r;
        if_instr_next_s = if_instr_r;
        if_pc_next_s    = if_pc_r;
        if_valid_next_s = if_valid_r;
        if (redirect_valid) begin
            pc_next_s       = redirect_target;
            if_valid_next_s = 1'b0;
        end else if (start_ok_s) begin
            pc_next_s       = RESET_PC;
            if_valid_next_s = 1'b0;
        end else if (fire_s) begin
            if_instr_next_s = rom_instruction;
            if_pc_next_s    = pc_r;
            if_valid_next_s = 1'b1;
            pc_next_s       = pc_r + PC_ONE;
        end else if (slot_free_s) begin
            if_valid_next_s = 1'b0;
        end else begin
            if_valid_next_s = if_valid_r;
        end
    end

    // State, PC and slot registers; status flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            if_instr_r <= {DATA_W{1'b0}};
            if_pc_r    <= {ADDR_W{1'b0}};
            if_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            if_instr_r <= if_instr_next_s;
            if_pc_r    <= if_pc_next_s;
            if_valid_r <= if_valid_next_s;
            busy_r     <= (state_next_s == ST_FETCH);
            halted_r   <= (state_next_s == ST_HALT);
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_r;

    // Transfer counter, restarted whenever a start is honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 32'd0;
        end else if (start_ok_s) begin
            fetch_count_r <= 32'd0;
        end else if (xfer_s) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign fetch_count = fetch_count_r;
`else
    logic unused_xfer_s;
    assign unused_xfer_s = xfer_s;
`endif

    assign rom_address = pc_r;
    assign if_instr    = if_instr_r;
    assign if_pc       = if_pc_r;
    assign if_valid    = if_valid_r;
    assign busy        = busy_r;
    assign halted      = halted_r;

endmodule
